// File: rtl/decoder_nxm_seq.sv
// Registered N-to-M one-hot decoder with enable, out-of-range flag and an
// autonomous scan mode that rotates the strobe with a programmable dwell.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  ST_OFF    | en low: strobe bank dark, idx 0, no pulses
//  ST_DIRECT | decode sel on sel_valid; hold last strobe otherwise
//  ST_SCAN   | rotate one-hot strobe, each position held dwell+1 cycles
module decoder_nxm_seq #(
   parameter int SEL_W   = 3,
   parameter int NUM_OUT = 8,
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic               sel_valid,
   input  logic [SEL_W-1:0]   sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [NUM_OUT-1:0] y,
   output logic [SEL_W-1:0]   idx,
   output logic               err,
   output logic               scan_wrap
);

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   // One bit wider than sel so NUM_OUT == 2**SEL_W compares correctly.
   localparam logic [SEL_W:0]   NUM_OUT_EXT = (SEL_W+1)'(NUM_OUT);
   localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_OUT - 1);

   state_t               state_q, state_d;
   logic [NUM_OUT-1:0]   y_d;
   logic [SEL_W-1:0]     idx_d;
   logic                 err_d;
   logic                 wrap_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic                 sel_in_range;

   assign sel_in_range = ({1'b0, sel} < NUM_OUT_EXT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_OFF;
         y         <= '0;
         idx       <= '0;
         err       <= 1'b0;
         scan_wrap <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         y         <= y_d;
         idx       <= idx_d;
         err       <= err_d;
         scan_wrap <= wrap_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      y_d     = y;
      idx_d   = idx;
      err_d   = 1'b0;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;

      if (!en) begin
         state_d = ST_OFF;
         y_d     = '0;
         idx_d   = '0;
         cnt_d   = '0;
      end else if (!mode) begin
         state_d = ST_DIRECT;
         if (sel_valid) begin
            if (sel_in_range) begin
               y_d   = NUM_OUT'(1) << sel;
               idx_d = sel;
            end else begin
               y_d   = '0;
               idx_d = '0;
               err_d = 1'b1;
            end
         end
      end else begin
         state_d = ST_SCAN;
         if (state_q != ST_SCAN) begin
            y_d   = NUM_OUT'(1);
            idx_d = '0;
            cnt_d = dwell;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
         end else begin
            // Terminal count: advance, reloading dwell as sampled now.
            cnt_d = dwell;
            if (idx == LAST_IDX) begin
               y_d    = NUM_OUT'(1);
               idx_d  = '0;
               wrap_d = 1'b1;
            end else begin
               y_d   = y << 1;
               idx_d = idx + SEL_W'(1);
            end
         end
      end
   end

endmodule
